llr_buf_ctrl: RTL

//  Sequencer for one LLR pair FIFO (DEPTH x SW*2, async read, wr/rd/reset, empty/full) between demapper and decoder.

---
 rtl/llr_buf_pkg.sv | 16 +
 rtl/llr_buf_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/llr_buf_pkg.sv
// Shared types and sizing for the LLR pair buffer controller.
package llr_buf_pkg;

    localparam int SW    = 4;
    localparam int ADDRW = 8;
    localparam int DEPTH = 256;
    localparam int LLR_W = SW * 2;
    localparam int CNT_W = ADDRW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        STREAM = 2'd2
    } state_t;

endpackage

// File: rtl/llr_buf_ctrl.sv
// Sequencer between the demapper and decoder for one LLR pair FIFO.
// Admits pairs with backpressure, tracks occupancy, launches a decoder
// block once blk_len pairs are buffered and streams exactly that many.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a valid blk_len and enough buffered pairs
// START  | one-cycle dec_start pulse, block length latched
// STREAM | presenting buffered pairs to the decoder until the last beat
module llr_buf_ctrl
    import llr_buf_pkg::*;
#(
    parameter int DEPTH_P = DEPTH,
    parameter int ADDRW_P = ADDRW,
    parameter int SW_P    = SW
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 flush,
    input  logic [ADDRW_P:0]     blk_len,
    input  logic [SW_P*2-1:0]    llr_in,
    input  logic                 llr_vld,
    output logic                 llr_rdy,
    output logic [SW_P*2-1:0]    buf_din,
    output logic                 buf_wr,
    output logic                 buf_rd,
    output logic                 buf_reset,
    input  logic [SW_P*2-1:0]    buf_dout,
    input  logic                 buf_empty,
    input  logic                 buf_full,
    output logic                 dec_start,
    output logic [SW_P*2-1:0]    dec_llr,
    output logic                 dec_vld,
    input  logic                 dec_rdy,
    output logic                 dec_last,
    output logic                 dec_abort,
    output logic                 busy,
    output logic                 cfg_err
);

    localparam int CW = ADDRW_P + 1;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] level;
    logic [CW-1:0] beat_cnt;
    logic [CW-1:0] len_q;
    logic          cfg_ok;

    assign cfg_ok = (blk_len != '0) && (blk_len <= CW'(DEPTH_P));

    // Write side and buffer control; flush blocks both ports that cycle.
    always_comb begin
        llr_rdy   = ~buf_full & ~flush;
        buf_wr    = llr_vld & llr_rdy;
        buf_din   = llr_in;
        buf_reset = flush;
        dec_llr   = buf_dout;
    end

    // Next-state decode and decoder-side strobes.
    always_comb begin
        state_nxt = state;
        dec_start = 1'b0;
        dec_vld   = 1'b0;
        dec_last  = 1'b0;
        buf_rd    = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (cfg_ok && (level >= blk_len)) state_nxt = START;
            end
            START: begin
                dec_start = 1'b1;
                state_nxt = STREAM;
            end
            STREAM: begin
                // Decoder must not see a beat it could consume during flush.
                dec_vld  = ~flush;
                dec_last = dec_vld & (beat_cnt == len_q - CW'(1));
                buf_rd   = dec_vld & dec_rdy & ~buf_empty;
                if (buf_rd && dec_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nxt;
    end

    // Occupancy mirror of the buffer.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)      level <= '0;
        else if (flush) level <= '0;
        else            level <= level + CW'(buf_wr) - CW'(buf_rd);
    end

    // Block length capture and beat counting.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            len_q    <= '0;
            beat_cnt <= '0;
        end else if (flush) begin
            beat_cnt <= '0;
        end else if (state == IDLE && state_nxt == START) begin
            len_q    <= blk_len;
            beat_cnt <= '0;
        end else if (buf_rd) begin
            beat_cnt <= beat_cnt + CW'(1);
        end
    end

    // Sticky config error and the abort pulse following a mid-block flush.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cfg_err   <= 1'b0;
            dec_abort <= 1'b0;
        end else begin
            dec_abort <= flush & (state != IDLE);
            if (flush)
                cfg_err <= 1'b0;
            else if (state == IDLE && !cfg_ok && level != '0)
                cfg_err <= 1'b1;
        end
    end

endmodule
